// File: rtl/slave_responder.sv
// slave_responder: slave-side endpoint of the req/ack bus.
// It takes one request at a time and serves it from a word-addressed register
// array after WAIT_CYCLES wait states. It answers with a one-cycle ack and
// registered read data. Addresses outside the array drop writes and read as zero.
module slave_responder #(
   parameter int N           = 32,
   parameter int DEPTH_BITS  = 4,
   parameter int WAIT_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         slave_req,
   input  logic [N-1:0] slave_addr,
   input  logic         slave_cmd,
   input  logic [N-1:0] slave_wdata,
   output logic         slave_ack,
   output logic [N-1:0] slave_rdata
);

   localparam int         DEPTH     = 2 ** DEPTH_BITS;
   localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [N-1:0]    addr_q, addr_d;
   logic            cmd_q, cmd_d;
   logic [N-1:0]    wdata_q, wdata_d;
   logic            ack_q, ack_d;
   logic [N-1:0]    rdata_q, rdata_d;
   logic [N-1:0]    mem_q [DEPTH];

   logic                  enter_ack_s;
   logic [N-1:0]          c_addr_s;
   logic                  c_cmd_s;
   logic [N-1:0]          c_wdata_s;
   logic                  in_range_s;
   logic [DEPTH_BITS-1:0] idx_s;
   logic                  mem_we_s;
   logic                  unused_s;

   // Next-state logic: accept in IDLE, count wait states, then one ACK cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      cmd_d       = cmd_q;
      wdata_d     = wdata_q;
      enter_ack_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (slave_req) begin
               addr_d  = slave_addr;
               cmd_d   = slave_cmd;
               wdata_d = slave_wdata;
               if (WAIT_INIT == 8'd0) begin
                  state_d     = ST_ACK;
                  cnt_d       = 8'd0;
                  enter_ack_s = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // The "<=" also covers a zero count, so the FSM can never get stuck here.
            if (cnt_q <= 8'd1) begin
               state_d     = ST_ACK;
               cnt_d       = 8'd0;
               enter_ack_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Commit source: with zero wait states the commit happens at the accept edge,
   // so the live inputs are used; otherwise the latched transaction is used.
   always_comb begin
      if (state_q == ST_IDLE) begin
         c_addr_s  = slave_addr;
         c_cmd_s   = slave_cmd;
         c_wdata_s = slave_wdata;
      end else begin
         c_addr_s  = addr_q;
         c_cmd_s   = cmd_q;
         c_wdata_s = wdata_q;
      end
   end

   assign in_range_s = (c_addr_s[N-1:DEPTH_BITS+2] == '0);
   assign idx_s      = c_addr_s[DEPTH_BITS+1:2];
   assign mem_we_s   = enter_ack_s & c_cmd_s & in_range_s;
   // Byte-offset bits have no function; there are no byte enables.
   assign unused_s   = &{1'b0, c_addr_s[1:0]};

   // Output next-state: ack and read data are set only for the ACK cycle.
   always_comb begin
      ack_d   = 1'b0;
      rdata_d = '0;
      if (enter_ack_s) begin
         ack_d = 1'b1;
         if (!c_cmd_s && in_range_s) begin
            rdata_d = mem_q[idx_s];
         end else begin
            rdata_d = '0;
         end
      end else begin
         ack_d   = 1'b0;
         rdata_d = '0;
      end
   end

   // Control and output registers. Reset aborts any in-flight transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= '0;
         cmd_q   <= 1'b0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         cmd_q   <= cmd_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   // Register array: cleared on reset, written only at the edge entering ACK.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we_s) begin
         mem_q[idx_s] <= c_wdata_s;
      end
   end

   assign slave_ack   = ack_q;
   assign slave_rdata = rdata_q;

endmodule

// File: tb/tb_slave_responder.sv
// Self-checking bench for slave_responder. It runs one instance with the default
// two wait states and one instance with zero wait states.
module tb_slave_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        req2 = 1'b0, cmd2 = 1'b0, ack2;
   logic [31:0] addr2 = 32'h0, wdata2 = 32'h0, rdata2;
   logic        req0 = 1'b0, cmd0 = 1'b0, ack0;
   logic [31:0] addr0 = 32'h0, wdata0 = 32'h0, rdata0;

   int checks   = 0;
   int failures = 0;

   logic [31:0] q2[$];
   logic [31:0] q0[$];

   typedef struct {
      logic        cmd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   slave_responder #(.N(32), .DEPTH_BITS(4), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .slave_req(req2), .slave_addr(addr2),
      .slave_cmd(cmd2), .slave_wdata(wdata2), .slave_ack(ack2), .slave_rdata(rdata2));

   slave_responder #(.N(32), .DEPTH_BITS(4), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .slave_req(req0), .slave_addr(addr0),
      .slave_cmd(cmd0), .slave_wdata(wdata0), .slave_ack(ack0), .slave_rdata(rdata0));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pop the expected value for instance sel (2 or 0); an empty queue is a failure.
   task automatic pop_chk(input int sel, input string name, input logic [31:0] act);
      logic [31:0] e;
      if (sel == 2 && q2.size() > 0) begin
         e = q2.pop_front();
         chk(name, act, e);
      end else if (sel == 0 && q0.size() > 0) begin
         e = q0.pop_front();
         chk(name, act, e);
      end else begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard empty actual=%h expected=none", name, act);
      end
   endtask

   // One transaction on the two-wait-state instance. The ack must be seen
   // after the 3rd edge counted from the accept edge. It must then drop after one cycle.
   task automatic txn2(input logic c, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp);
      int n;
      @(negedge clk);
      req2 = 1'b1; cmd2 = c; addr2 = a; wdata2 = wd;
      q2.push_back(exp);
      n = 0;
      do begin
         tick();
         n++;
         if (n == 1) begin
            req2 = 1'b0;
            wdata2 = 32'hDEAD_0000;
         end
      end while (!ack2 && n < 20);
      chk("txn_latency", 32'(n), 32'd3);
      pop_chk(2, "txn_rdata", rdata2);
      tick();
      chk("txn_ack_fall", {31'd0, ack2}, 32'd0);
      chk("txn_rdata_fall", rdata2, 32'd0);
   endtask

   initial begin
      vec_t vecs[12];
      logic [31:0] last_w;
      logic [31:0] nxt;
      int acks, k, phase, last_c;

      vecs[0]  = '{1'b0, 32'h0000_003C, 32'h0,           32'h0};
      vecs[1]  = '{1'b1, 32'h0000_0008, 32'h1111_1111,   32'h0};
      vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,           32'h1111_1111};
      vecs[3]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF,   32'h0};
      vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0,           32'h0};
      vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,           32'h0};
      vecs[6]  = '{1'b1, 32'h0000_000B, 32'h2222_2222,   32'h0};
      vecs[7]  = '{1'b0, 32'h0000_0008, 32'h0,           32'h2222_2222};
      vecs[8]  = '{1'b1, 32'h0000_003C, 32'hDEAD_BEEF,   32'h0};
      vecs[9]  = '{1'b0, 32'h0000_003F, 32'h0,           32'hDEAD_BEEF};
      vecs[10] = '{1'b0, 32'h0000_0040, 32'h0,           32'h0};
      vecs[11] = '{1'b0, 32'h0000_003C, 32'h0,           32'hDEAD_BEEF};

      // Reset held while a request is pending: no ack, rdata zero.
      rst = 1'b0; req2 = 1'b1; cmd2 = 1'b1; addr2 = 32'h8; wdata2 = 32'h5555_5555;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_ack", {31'd0, ack2}, 32'd0);
         chk("reset_rdata", rdata2, 32'd0);
      end
      @(negedge clk);
      rst = 1'b1; req2 = 1'b0;

      // Table-driven single transactions.
      for (int i = 0; i < 12; i++) begin
         txn2(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      end

      // req held high while cmd alternates write/read at 0x04. Changes made
      // during WAIT must be ignored.
      @(negedge clk);
      last_w = 32'h1000_0000;
      req2 = 1'b1; cmd2 = 1'b1; addr2 = 32'h4; wdata2 = last_w;
      q2.push_back(32'h0);
      acks = 0; k = 1; phase = 0; last_c = 0;
      for (int c = 0; c < 60 && acks < 6; c++) begin
         tick();
         if (ack2) begin
            acks++;
            pop_chk(2, "b2b_rdata", rdata2);
            if (acks > 1) chk("b2b_period", 32'(c - last_c), 32'd4);
            last_c = c;
            phase = 0;
            if (acks < 6) begin
               addr2 = 32'h4;
               if (k % 2 == 1) begin
                  cmd2 = 1'b0; wdata2 = 32'h0;
                  q2.push_back(last_w);
               end else begin
                  nxt = 32'h1000_0000 + 32'(k) * 32'h0000_0101;
                  cmd2 = 1'b1; wdata2 = nxt; last_w = nxt;
                  q2.push_back(32'h0);
               end
               k++;
            end else begin
               req2 = 1'b0;
            end
         end else begin
            phase++;
            if (phase == 2) begin
               wdata2 = 32'hBAD0_BAD0; addr2 = 32'h0000_0038; cmd2 = ~cmd2;
            end
         end
      end
      chk("b2b_ack_count", 32'(acks), 32'd6);
      tick();
      chk("b2b_ack_fall", {31'd0, ack2}, 32'd0);
      txn2(1'b0, 32'h0000_0038, 32'h0, 32'h0);

      // Reset during WAIT of a write aborts it.
      @(negedge clk);
      req2 = 1'b1; cmd2 = 1'b1; addr2 = 32'h0C; wdata2 = 32'hA5A5_A5A5;
      tick();
      req2 = 1'b0;
      #2 rst = 1'b0;
      #1 chk("midrst_ack", {31'd0, ack2}, 32'd0);
      tick();
      chk("midrst_ack_hold", {31'd0, ack2}, 32'd0);
      chk("midrst_rdata", rdata2, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      chk("midrst_no_ack", {31'd0, ack2}, 32'd0);
      txn2(1'b0, 32'h0000_000C, 32'h0, 32'h0);
      txn2(1'b0, 32'h0000_0008, 32'h0, 32'h0);

      // Zero wait states: ack after the first edge, 2-cycle period with req held.
      @(negedge clk);
      req0 = 1'b1; cmd0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hCAFE_F00D;
      q0.push_back(32'h0);
      tick();
      chk("w0_write_ack", {31'd0, ack0}, 32'd1);
      pop_chk(0, "w0_write_rdata", rdata0);
      cmd0 = 1'b0; wdata0 = 32'h0;
      q0.push_back(32'hCAFE_F00D);
      tick();
      chk("w0_gap_ack", {31'd0, ack0}, 32'd0);
      tick();
      chk("w0_read_ack", {31'd0, ack0}, 32'd1);
      pop_chk(0, "w0_read_rdata", rdata0);
      req0 = 1'b0;
      tick();
      chk("w0_ack_fall", {31'd0, ack0}, 32'd0);
      chk("w0_rdata_fall", rdata0, 32'd0);

      chk("scoreboard_drained", 32'(q2.size() + q0.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
